// File: rtl/nidhogg_pkg.sv
// Shared constants and types for the win overlay: FSM encoding, winner codes,
// colour key and the pixel-timing bundle carried down the pipeline.
package nidhogg_pkg;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned RGB_W   = 12;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ANNOUNCE = 2'd1;
   localparam logic [1:0] ST_HOLD     = 2'd2;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   localparam logic [RGB_W-1:0] KEY_COLOR = 12'h198;

   typedef struct packed {
      logic [COORD_W-1:0] hcount;
      logic [COORD_W-1:0] vcount;
      logic               hsync;
      logic               vsync;
      logic               hblnk;
      logic               vblnk;
   } timing_t;

   function automatic logic is_valid_winner(input logic [1:0] w);
      return (w == WIN_LEFT) || (w == WIN_RIGHT);
   endfunction

endpackage

// File: rtl/sprite_window.sv
// Half-open square sprite window: flags pos <= count < pos+SIZE on both axes
// and forms the {y,x} ROM address from the truncated offsets.
module sprite_window #(
   parameter int unsigned SIZE = 32
) (
   input  logic [11:0]               hcount,
   input  logic [11:0]               vcount,
   input  logic [11:0]               pos_x,
   input  logic [11:0]               pos_y,
   output logic                      hit_c,
   output logic [2*$clog2(SIZE)-1:0] addr_c
);

   localparam int unsigned AW = $clog2(SIZE);

   logic [11:0] dx;
   logic [11:0] dy;

   assign dx = hcount - pos_x;
   assign dy = vcount - pos_y;

   // Offset compare works because the lower bound is checked separately.
   assign hit_c  = (hcount >= pos_x) && (dx < 12'(SIZE)) &&
                   (vcount >= pos_y) && (dy < 12'(SIZE));
   assign addr_c = {dy[AW-1:0], dx[AW-1:0]};

endmodule

// File: rtl/win_overlay.sv
// Winner announcement overlay: two blinking sign sprites plus a crown over a
// background video stream, with a two-stage pipeline aligned to the timing.
module win_overlay #(
   parameter int unsigned SIGN_SIZE       = 128,
   parameter int unsigned CROWN_SIZE      = 32,
   parameter logic [11:0] KEY_COLOR       = nidhogg_pkg::KEY_COLOR,
   parameter int unsigned SIGN_X          = 384,
   parameter int unsigned SIGN_Y          = 384,
   parameter int unsigned CROWN_XL        = 91,
   parameter int unsigned CROWN_XR        = 901,
   parameter int unsigned CROWN_Y         = 581,
   parameter int unsigned BLINK_FRAMES    = 15,
   parameter int unsigned ANNOUNCE_FRAMES = 180
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [11:0]                     hcount_in,
   input  logic [11:0]                     vcount_in,
   input  logic                            hsync_in,
   input  logic                            vsync_in,
   input  logic                            hblnk_in,
   input  logic                            vblnk_in,
   input  logic [11:0]                     rgb_in,
   input  logic [1:0]                      winner,
   input  logic                            winner_valid,
   input  logic                            clear,
   input  logic [11:0]                     rgb_sign_left,
   input  logic [11:0]                     rgb_sign_right,
   input  logic [11:0]                     rgb_crown,
   output logic [2*$clog2(SIGN_SIZE)-1:0]  addr_sign_left,
   output logic [2*$clog2(SIGN_SIZE)-1:0]  addr_sign_right,
   output logic [2*$clog2(CROWN_SIZE)-1:0] addr_crown,
   output logic [11:0]                     hcount_out,
   output logic [11:0]                     vcount_out,
   output logic                            hsync_out,
   output logic                            vsync_out,
   output logic                            hblnk_out,
   output logic                            vblnk_out,
   output logic [11:0]                     rgb_out,
   output logic                            active
);

   import nidhogg_pkg::*;

   localparam int unsigned SA_W    = 2 * $clog2(SIGN_SIZE);
   localparam int unsigned CA_W    = 2 * $clog2(CROWN_SIZE);
   localparam int unsigned FRAME_W = $clog2(ANNOUNCE_FRAMES + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

   logic [1:0]         state, state_n;
   logic [1:0]         win_q, win_n;
   logic [FRAME_W-1:0] frames, frames_n;
   logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
   logic               blink_off, blink_off_n;
   logic               vsync_prev;
   logic               tick;

   assign tick = vsync_in && !vsync_prev;

   // Control state: FSM, latched winner, frame and blink counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         win_q      <= WIN_NONE;
         frames     <= '0;
         blink_cnt  <= '0;
         blink_off  <= 1'b0;
         vsync_prev <= 1'b0;
         active     <= 1'b0;
      end else begin
         state      <= state_n;
         win_q      <= win_n;
         frames     <= frames_n;
         blink_cnt  <= blink_cnt_n;
         blink_off  <= blink_off_n;
         vsync_prev <= vsync_in;
         active     <= (state_n != ST_IDLE);
      end
   end

   // Counters restart on every state entry so each phase begins visible.
   always_comb begin
      state_n     = state;
      win_n       = win_q;
      frames_n    = frames;
      blink_cnt_n = blink_cnt;
      blink_off_n = blink_off;
      if (clear) begin
         state_n     = ST_IDLE;
         win_n       = WIN_NONE;
         frames_n    = '0;
         blink_cnt_n = '0;
         blink_off_n = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (winner_valid && is_valid_winner(winner)) begin
                  state_n     = ST_ANNOUNCE;
                  win_n       = winner;
                  frames_n    = '0;
                  blink_cnt_n = '0;
                  blink_off_n = 1'b0;
               end
            end
            ST_ANNOUNCE: begin
               if (tick) begin
                  if (frames == FRAME_W'(ANNOUNCE_FRAMES - 1)) begin
                     state_n     = ST_HOLD;
                     frames_n    = '0;
                     blink_cnt_n = '0;
                     blink_off_n = 1'b0;
                  end else begin
                     frames_n = frames + 1'b1;
                     if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_n = '0;
                        blink_off_n = !blink_off;
                     end else begin
                        blink_cnt_n = blink_cnt + 1'b1;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (tick && (frames != '1)) frames_n = frames + 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   logic              sign_vis, crown_vis;
   logic [11:0]       crown_x;
   logic              hit_l, hit_r, hit_c;
   logic [SA_W-1:0]   addr_l_c, addr_r_c;
   logic [CA_W-1:0]   addr_c_c;

   assign sign_vis  = (state == ST_HOLD) || ((state == ST_ANNOUNCE) && !blink_off);
   assign crown_vis = (state == ST_ANNOUNCE) || (state == ST_HOLD);
   assign crown_x   = (win_q == WIN_RIGHT) ? 12'(CROWN_XR) : 12'(CROWN_XL);

   sprite_window #(.SIZE(SIGN_SIZE)) u_sign_left (
      .hcount (hcount_in), .vcount (vcount_in),
      .pos_x  (12'(SIGN_X)), .pos_y (12'(SIGN_Y)),
      .hit_c  (hit_l), .addr_c (addr_l_c)
   );

   sprite_window #(.SIZE(SIGN_SIZE)) u_sign_right (
      .hcount (hcount_in), .vcount (vcount_in),
      .pos_x  (12'(SIGN_X + SIGN_SIZE)), .pos_y (12'(SIGN_Y)),
      .hit_c  (hit_r), .addr_c (addr_r_c)
   );

   sprite_window #(.SIZE(CROWN_SIZE)) u_crown (
      .hcount (hcount_in), .vcount (vcount_in),
      .pos_x  (crown_x), .pos_y (12'(CROWN_Y)),
      .hit_c  (hit_c), .addr_c (addr_c_c)
   );

   timing_t          t1;
   logic [RGB_W-1:0] rgb1;
   logic             hit_l1, hit_r1, hit_c1;
   logic [RGB_W-1:0] pix_c;

   // Stage 1: timing, background, gated region flags and ROM addresses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t1              <= '0;
         rgb1            <= '0;
         hit_l1          <= 1'b0;
         hit_r1          <= 1'b0;
         hit_c1          <= 1'b0;
         addr_sign_left  <= '0;
         addr_sign_right <= '0;
         addr_crown      <= '0;
      end else begin
         t1              <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
         rgb1            <= rgb_in;
         hit_l1          <= hit_l && sign_vis;
         hit_r1          <= hit_r && sign_vis;
         hit_c1          <= hit_c && crown_vis;
         addr_sign_left  <= addr_l_c;
         addr_sign_right <= addr_r_c;
         addr_crown      <= addr_c_c;
      end
   end

   // Priority composite; keyed sprite pixels fall through.
   always_comb begin
      pix_c = rgb1;
      if (t1.hblnk || t1.vblnk)                   pix_c = '0;
      else if (hit_c1 && rgb_crown != KEY_COLOR)  pix_c = rgb_crown;
      else if (hit_l1 && rgb_sign_left != KEY_COLOR)  pix_c = rgb_sign_left;
      else if (hit_r1 && rgb_sign_right != KEY_COLOR) pix_c = rgb_sign_right;
   end

   // Stage 2: composited pixel and re-registered timing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb_out    <= '0;
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
      end else begin
         rgb_out    <= pix_c;
         hcount_out <= t1.hcount;
         vcount_out <= t1.vcount;
         hsync_out  <= t1.hsync;
         vsync_out  <= t1.vsync;
         hblnk_out  <= t1.hblnk;
         vblnk_out  <= t1.vblnk;
      end
   end

endmodule

// File: tb/tb_win_overlay.sv
// Self-checking bench for win_overlay: a behavioural reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_win_overlay;

   localparam int KEY = 12'h198;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [1:0]  winner = '0;
   logic        winner_valid = 1'b0, clear = 1'b0;
   logic [11:0] rgb_sign_left, rgb_sign_right, rgb_crown;
   logic [13:0] addr_sign_left, addr_sign_right;
   logic [9:0]  addr_crown;
   logic [11:0] hcount_out, vcount_out, rgb_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out, active;

   win_overlay dut (
      .clk(clk), .reset(reset),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .winner(winner), .winner_valid(winner_valid), .clear(clear),
      .rgb_sign_left(rgb_sign_left), .rgb_sign_right(rgb_sign_right), .rgb_crown(rgb_crown),
      .addr_sign_left(addr_sign_left), .addr_sign_right(addr_sign_right), .addr_crown(addr_crown),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .active(active)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ROM contents: either a fixed override per sprite or an address hash with keyed holes.
   bit use_ov = 1'b1;
   int ov_l = 12'h0F0, ov_r = 12'h00F, ov_c = 12'hF00;

   function automatic int rom_fn(input int id, input int addr, input bit ov_en, input int ov);
      if (ov_en) return ov;
      if ((addr + id) % 7 == 0) return KEY;
      return (addr * 37 + id * 1013 + 5) % 4096;
   endfunction

   always_comb begin
      rgb_sign_left  = 12'(rom_fn(0, int'(addr_sign_left), use_ov, ov_l));
      rgb_sign_right = 12'(rom_fn(1, int'(addr_sign_right), use_ov, ov_r));
      rgb_crown      = 12'(rom_fn(2, int'(addr_crown), use_ov, ov_c));
   end

   // ---------------- reference model ----------------
   typedef struct {
      int h, v; bit hs, vs, hb, vb; int rgb;
      bit il, ir, ic; int al, ar, ac;
   } pix_t;

   pix_t s1, outp;
   int   m_state, m_win, m_frames;
   bit   m_vs_prev;

   function automatic bit inside_sq(input int h, input int v, input int x, input int y, input int s);
      return (h >= x) && (h < x + s) && (v >= y) && (v < y + s);
   endfunction

   function automatic int addr_of(input int h, input int v, input int x, input int y, input int s);
      return (((v - y) & (s - 1)) * s) + ((h - x) & (s - 1));
   endfunction

   function automatic pix_t make_s1(input int st, input int win, input int fr);
      pix_t p;
      bit sv, cv;
      int cx;
      sv = (st == 2) || ((st == 1) && (((fr / 15) % 2) == 0));
      cv = (st != 0);
      cx = (win == 2) ? 901 : 91;
      p.h = int'(hcount_in); p.v = int'(vcount_in);
      p.hs = hsync_in; p.vs = vsync_in; p.hb = hblnk_in; p.vb = vblnk_in;
      p.rgb = int'(rgb_in);
      p.il = sv && inside_sq(p.h, p.v, 384, 384, 128);
      p.ir = sv && inside_sq(p.h, p.v, 512, 384, 128);
      p.ic = cv && inside_sq(p.h, p.v, cx, 581, 32);
      p.al = addr_of(p.h, p.v, 384, 384, 128);
      p.ar = addr_of(p.h, p.v, 512, 384, 128);
      p.ac = addr_of(p.h, p.v, cx, 581, 32);
      return p;
   endfunction

   function automatic pix_t finish_px(input pix_t p, input bit oe, input int ol, input int orr, input int oc);
      pix_t q;
      int cl, cr, cc;
      q  = p;
      cl = rom_fn(0, p.al, oe, ol);
      cr = rom_fn(1, p.ar, oe, orr);
      cc = rom_fn(2, p.ac, oe, oc);
      if (p.hb || p.vb)           q.rgb = 0;
      else if (p.ic && cc != KEY) q.rgb = cc;
      else if (p.il && cl != KEY) q.rgb = cl;
      else if (p.ir && cr != KEY) q.rgb = cr;
      return q;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1        <= '{default: 0};
         outp      <= '{default: 0};
         m_state   <= 0;
         m_win     <= 0;
         m_frames  <= 0;
         m_vs_prev <= 1'b0;
      end else begin
         outp      <= finish_px(s1, use_ov, ov_l, ov_r, ov_c);
         s1        <= make_s1(m_state, m_win, m_frames);
         m_vs_prev <= vsync_in;
         if (clear) begin
            m_state <= 0; m_win <= 0; m_frames <= 0;
         end else if (m_state == 0) begin
            if (winner_valid && (winner == 2'b01 || winner == 2'b10)) begin
               m_state <= 1; m_win <= int'(winner); m_frames <= 0;
            end
         end else if (vsync_in && !m_vs_prev) begin
            if (m_state == 1 && m_frames + 1 == 180) begin
               m_state <= 2; m_frames <= 0;
            end else begin
               m_frames <= m_frames + 1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("rgb_out",    int'(rgb_out),    outp.rgb);
      check("hcount_out", int'(hcount_out), outp.h);
      check("vcount_out", int'(vcount_out), outp.v);
      check("sync_blank", int'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
            int'({outp.hs, outp.vs, outp.hb, outp.vb}));
      check("addr_left",  int'(addr_sign_left),  s1.al);
      check("addr_right", int'(addr_sign_right), s1.ar);
      check("addr_crown", int'(addr_crown),      s1.ac);
      check("active",     int'(active),          int'(m_state != 0));
   end

   // ---------------- stimulus ----------------
   task automatic px(input int h, input int v, input int rgb, input int n);
      hcount_in = 12'(h); vcount_in = 12'(v); rgb_in = 12'(rgb);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         vsync_in = 1'b1; @(negedge clk);
         vsync_in = 1'b0; @(negedge clk);
      end
   endtask

   function automatic int pick_h();
      case ($urandom_range(0, 3))
         0: return $urandom_range(380, 650);
         1: return $urandom_range(85, 130);
         2: return $urandom_range(895, 940);
         default: return $urandom_range(0, 1023);
      endcase
   endfunction

   function automatic int pick_v();
      case ($urandom_range(0, 2))
         0: return $urandom_range(378, 520);
         1: return $urandom_range(575, 620);
         default: return $urandom_range(0, 767);
      endcase
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      check("reset_rgb", int'(rgb_out), 0);
      check("reset_active", int'(active), 0);
      reset = 1'b1;

      // Idle pass-through; the address is still produced.
      px(400, 400, 12'hABC, 3);
      check("idle_rgb", int'(rgb_out), 12'hABC);
      check("idle_addr", int'(addr_sign_left), 14'h0810);

      // Left winner, crown at the left position.
      winner = 2'b01; winner_valid = 1'b1; @(negedge clk);
      winner_valid = 1'b0; winner = 2'b00;
      px(100, 590, 12'h123, 3);
      check("crown_pix", int'(rgb_out), 12'hF00);
      check("crown_addr", int'(addr_crown), 10'h129);
      check("announce_active", int'(active), 1);
      ov_c = KEY;
      px(100, 590, 12'h123, 3);
      check("crown_key", int'(rgb_out), 12'h123);
      ov_c = 12'hF00;

      // Blinking of the signs by frame count, then HOLD.
      px(400, 400, 12'h0AA, 3);
      check("blink_f0", int'(rgb_out), 12'h0F0);
      frame_ticks(15); px(400, 400, 12'h0AA, 3);
      check("blink_f15", int'(rgb_out), 12'h0AA);
      frame_ticks(15); px(400, 400, 12'h0AA, 3);
      check("blink_f30", int'(rgb_out), 12'h0F0);
      frame_ticks(149); px(400, 400, 12'h0AA, 3);
      check("blink_f179", int'(rgb_out), 12'h0AA);
      frame_ticks(1); px(400, 400, 12'h0AA, 3);
      check("hold_sign", int'(rgb_out), 12'h0F0);
      check("hold_active", int'(active), 1);

      // Left/right sign boundary and blanking.
      px(511, 400, 12'h0AA, 3);
      check("edge_511", int'(rgb_out), 12'h0F0);
      px(512, 400, 12'h0AA, 3);
      check("edge_512", int'(rgb_out), 12'h00F);
      hblnk_in = 1'b1; px(512, 400, 12'h0AA, 3);
      check("hblank", int'(rgb_out), 0);
      hblnk_in = 1'b0;

      // Clear wins over a simultaneous strobe.
      clear = 1'b1; winner_valid = 1'b1; winner = 2'b10; @(negedge clk);
      clear = 1'b0; winner_valid = 1'b0; winner = 2'b00;
      px(100, 590, 12'h321, 3);
      check("clear_active", int'(active), 0);
      check("clear_crown", int'(rgb_out), 12'h321);
      px(910, 590, 12'h321, 3);
      check("clear_crown_r", int'(rgb_out), 12'h321);

      // Random traffic checked by the model.
      use_ov = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         hcount_in    = 12'(pick_h());
         vcount_in    = 12'(pick_v());
         rgb_in       = 12'($urandom_range(0, 4095));
         hsync_in     = 1'($urandom_range(0, 1));
         vsync_in     = 1'($urandom_range(0, 1));
         hblnk_in     = ($urandom_range(0, 9) == 0);
         vblnk_in     = ($urandom_range(0, 19) == 0);
         winner       = 2'($urandom_range(0, 3));
         winner_valid = ($urandom_range(0, 49) == 0);
         clear        = ($urandom_range(0, 1499) == 0);
         @(negedge clk);
      end
      clear = 1'b0; winner_valid = 1'b0;

      // Reset in the middle of a frame clears outputs immediately.
      #2 reset = 1'b0;
      #1;
      check("midreset_rgb", int'(rgb_out), 0);
      check("midreset_active", int'(active), 0);
      check("midreset_hcount", int'(hcount_out), 0);
      check("midreset_addr", int'(addr_sign_left), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/win_overlay.md
WIN_OVERLAY -- requirements
Module: win_overlay

Interface
REQ-001 Parameter SIGN_SIZE, default 128, meaning side in pixels of each square sign sprite (power of two).
REQ-002 Parameter CROWN_SIZE, default 32, meaning side in pixels of the square crown sprite (power of two).
REQ-003 Parameter KEY_COLOR, default 12'h198, meaning transparent colour key for all sprites.
REQ-004 Parameters SIGN_X/SIGN_Y, default 384/384; CROWN_XL/CROWN_XR/CROWN_Y, default 91/901/581, meaning sprite top-left positions; the right sign sits at SIGN_X+SIGN_SIZE.
REQ-005 Parameters BLINK_FRAMES, default 15, and ANNOUNCE_FRAMES, default 180, meaning the blink half-period and the announce duration, both in frames.
REQ-006 clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 hcount_in/vcount_in  in  12 each  pixel coordinates; hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing.
REQ-009 rgb_in  in  12  background pixel.
REQ-010 winner  in  2  01 left, 10 right; 00 and 11 are invalid.
REQ-011 winner_valid  in  1  single-cycle strobe qualifying winner.
REQ-012 clear  in  1  level input that returns the block to idle.
REQ-013 rgb_sign_left, rgb_sign_right, rgb_crown  in  12 each  ROM data, returned 1 cycle after the address.
REQ-014 addr_sign_left, addr_sign_right  out  2*log2(SIGN_SIZE) each  {y,x} ROM address.
REQ-015 addr_crown  out  2*log2(CROWN_SIZE)  {y,x} ROM address.
REQ-016 hcount_out, vcount_out, sync and blank outputs  out  as inputs  timing delayed by exactly 2 cycles.
REQ-017 rgb_out  out  12  composited pixel, aligned with the delayed timing.
REQ-018 active  out  1  high in ANNOUNCE and HOLD.

Function
REQ-019 Stage 1 shall register the timing, the rgb_in value, the in-region flags and the ROM addresses; address = (count - position) truncated to the sprite's log2 width.
REQ-020 Stage 2 shall combine the stage-1 flags with the ROM data, register rgb_out, and re-register the timing.
REQ-021 Total latency from the timing inputs to every output shall be 2 cycles.
REQ-022 Sprite regions are half-open: pos <= count < pos+SIZE on both axes.
REQ-023 Priority: blank gives 000; otherwise crown, then left sign, then right sign, then background.
REQ-024 A sprite pixel equal to KEY_COLOR shall be treated as transparent and fall through to the next priority.
REQ-025 FSM states: IDLE, ANNOUNCE, HOLD.
REQ-026 IDLE -> ANNOUNCE on winner_valid with a valid winner, which latches winner; an invalid code shall be ignored.
REQ-027 ANNOUNCE -> HOLD after ANNOUNCE_FRAMES frame ticks.
REQ-028 Any state -> IDLE on the cycle after clear is sampled high; clear has priority over winner_valid.
REQ-029 winner_valid shall be ignored outside IDLE; the latched winner is stable.
REQ-030 Frame tick = vsync_in rising edge, detected with a registered previous value; the frame counter saturates and is cleared on state entry.
REQ-031 In ANNOUNCE, signs are visible while floor(frames/BLINK_FRAMES) is even; in HOLD they are always visible; in IDLE sprites are never drawn and rgb_out = rgb_in delayed.
REQ-032 The crown is drawn at CROWN_XL when the latched winner is 01 and at CROWN_XR when it is 10, in both ANNOUNCE and HOLD, without blinking.
REQ-033 Visibility changes shall be taken only at frame ticks, never mid-frame.

Reset
REQ-034 While reset is low, all outputs, pipeline registers and counters are 0, FSM = IDLE, latched winner = 00; release takes effect on the next clk edge.

Structure
REQ-035 State encoding, winner codes and KEY_COLOR shall be placed in the shared package nidhogg_pkg.
REQ-036 One sub-module sprite_window (parametrised size and position; outputs in-region flag and address) shall be instantiated three times.

Verification
REQ-037 Reset low mid-frame -> all outputs 0 and active=0 within the same cycle.
REQ-038 IDLE, rgb_in=12'hABC at (400,400) -> rgb_out=12'hABC two cycles later; the address is still driven.
REQ-039 winner=01 strobe, then pixel (100,590) with crown ROM 12'hF00 -> rgb_out=12'hF00; with ROM 12'h198 -> rgb_in.
REQ-040 ANNOUNCE, frames 0-14 -> sign pixel 12'h0F0 shown; frames 15-29 -> background; HOLD is entered after 180 ticks with active=1.
REQ-041 clear and winner_valid asserted in the same cycle in HOLD -> IDLE, winner=00, active=0.
REQ-042 hcount_in=511 vs 512 with both signs opaque -> left sign pixel vs right sign pixel (boundary); hblnk_in=1 -> 000.
